add_sched_ctrl: RTL

//  Shares one WIDTH-bit adder/half-adder unit between two requesters (0, 1).

---
 rtl/add_sched_ctrl_pkg.sv | 19 +
 rtl/add_sched_ctrl_if.sv | 28 ++
 rtl/add_sched_ctrl_add_unit.sv | 27 ++
 rtl/add_sched_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/add_sched_ctrl_pkg.sv
// Shared types for the two-requester adder scheduler: op codes, FSM states, default width.
package add_sched_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ACC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_HALF = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/add_sched_ctrl_if.sv
// Request/response handshake bundle for both requesters; index N selects the requester.
interface add_sched_ctrl_if
  import add_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][1:0]       req_op;
  logic [1:0][WIDTH-1:0] req_x;
  logic [1:0][WIDTH-1:0] req_y;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [1:0][WIDTH-1:0] rsp_sum;
  logic [1:0]            rsp_cout;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/add_sched_ctrl_add_unit.sv
// Combinational WIDTH-bit adder with a bit-0 half-add mode.
module add_unit
  import add_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             half,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    if (half) begin
      sum  = {{(WIDTH-1){1'b0}}, a[0] ^ b[0]};
      cout = a[0] & b[0];
    end else begin
      sum  = full[WIDTH-1:0];
      cout = full[WIDTH];
    end
  end

endmodule

// File: rtl/add_sched_ctrl.sv
// Round-robin scheduler sharing one add_unit between two requesters,
// with one op in flight and a private accumulator per requester.
module add_sched_ctrl
  import add_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  add_sched_ctrl_if.slave bus,
  output logic            busy,
  output logic            last_grant
);

  state_e           state_q, state_d;
  logic             accept, grant_d, grant_q, last_grant_q;
  op_e              op_q;
  logic [WIDTH-1:0] x_q, y_q, sum_q;
  logic             cout_q;
  logic [WIDTH-1:0] a_s, b_s, unit_sum;
  logic             half_s, unit_cout;
  logic [WIDTH-1:0] acc_rd [2];

  // Contest: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    grant_d = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    accept  = (state_q == S_IDLE) && ena && (|bus.req_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (bus.rsp_ready[grant_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bus.req_ready[i] = rst_n && accept && (grant_d == 1'(i));
      bus.rsp_valid[i] = (state_q == S_RESP) && (grant_q == 1'(i));
      bus.rsp_sum[i]   = sum_q;
      bus.rsp_cout[i]  = cout_q;
    end
    busy       = (state_q != S_IDLE);
    last_grant = last_grant_q;
  end

  // ACC feeds the granted accumulator into the a-side; y is unused then.
  always_comb begin
    a_s    = x_q;
    b_s    = y_q;
    half_s = (op_q == OP_HALF);
    if (op_q == OP_ACC) begin
      a_s = acc_rd[grant_q];
      b_s = x_q;
    end
  end

  add_unit #(.WIDTH(WIDTH)) u_add (
    .a    (a_s),
    .b    (b_s),
    .half (half_s),
    .sum  (unit_sum),
    .cout (unit_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= OP_ADD;
      x_q          <= '0;
      y_q          <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
    end else begin
      if (accept) begin
        grant_q      <= grant_d;
        last_grant_q <= grant_d;
        op_q         <= op_e'(bus.req_op[grant_d]);
        x_q          <= bus.req_x[grant_d];
        y_q          <= bus.req_y[grant_d];
      end
      if (state_q == S_EXEC) begin
        sum_q  <= (op_q == OP_CLR) ? '0   : unit_sum;
        cout_q <= (op_q == OP_CLR) ? 1'b0 : unit_cout;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_acc
      logic [WIDTH-1:0] acc_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
        end else if (state_q == S_EXEC && grant_q == 1'(gi)) begin
          if (op_q == OP_ACC)      acc_q <= unit_sum;
          else if (op_q == OP_CLR) acc_q <= '0;
        end
      end

      assign acc_rd[gi] = acc_q;
    end
  endgenerate

endmodule
